// File: rtl/hazard_stall_unit_if.sv
// Pipeline-control bundle between the ID/EX/MEM datapath and hazard_stall_unit.
// The master side (datapath) drives hazard inputs; the slave side returns controls.
interface hazard_stall_unit_if;
    logic        IDEX_MemRead_In;
    logic [4:0]  IDEX_Rt_In;
    logic        IDEX_IsMul_In;
    logic [4:0]  IFID_Rs_In;
    logic [4:0]  IFID_Rt_In;
    logic        IFID_UsesRt_In;
    logic        BranchTaken_In;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXWrite;
    logic        IDEXFlush;
    logic        EXMEMFlush;
    logic        Busy;
    logic [15:0] StallCycles;

    modport master (
        output IDEX_MemRead_In, IDEX_Rt_In, IDEX_IsMul_In,
        output IFID_Rs_In, IFID_Rt_In, IFID_UsesRt_In, BranchTaken_In,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite,
        input  IDEXFlush, EXMEMFlush, Busy, StallCycles
    );

    modport slave (
        input  IDEX_MemRead_In, IDEX_Rt_In, IDEX_IsMul_In,
        input  IFID_Rs_In, IFID_Rt_In, IFID_UsesRt_In, BranchTaken_In,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite,
        output IDEXFlush, EXMEMFlush, Busy, StallCycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use stall, multi-cycle multiply stall and taken-branch flush control,
// with a saturating count of cycles in which the PC was held.
module hazard_stall_unit #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 3
) (
    input  logic               Clk,
    input  logic               Reset_n,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic {S_IDLE, S_MUL_WAIT} state_t;

    localparam logic [CNT_W-1:0] L_MUL_INIT =
        (MUL_LATENCY >= 2) ? CNT_W'(MUL_LATENCY - 2) : '0;
    localparam bit L_MUL_EN  = (MUL_LATENCY >= 2);
    localparam bit L_MUL_TWO = (MUL_LATENCY == 2);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mul_rel;
    logic [15:0]      r_stall_cnt;

    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_rel_nx;
    logic             w_pc_we;
    logic             w_ifid_we;
    logic             w_idex_we;
    logic             w_ifid_fl;
    logic             w_idex_fl;
    logic             w_exmem_fl;
    logic             w_mul_hit;
    logic             w_load_use;

    assign w_mul_hit = L_MUL_EN && hz.IDEX_IsMul_In && !r_mul_rel;

    assign w_load_use = hz.IDEX_MemRead_In && (hz.IDEX_Rt_In != 5'd0) &&
                        ((hz.IDEX_Rt_In == hz.IFID_Rs_In) ||
                         (hz.IFID_UsesRt_In &&
                          (hz.IDEX_Rt_In == hz.IFID_Rt_In)));

    always_comb begin
        w_pc_we    = 1'b1;
        w_ifid_we  = 1'b1;
        w_idex_we  = 1'b1;
        w_ifid_fl  = 1'b0;
        w_idex_fl  = 1'b0;
        w_exmem_fl = 1'b0;
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rel_nx   = r_mul_rel;

        // The branch is older than anything in ID/EX, so it aborts a multiply.
        if (hz.BranchTaken_In) begin
            w_ifid_fl  = 1'b1;
            w_idex_fl  = 1'b1;
            w_exmem_fl = 1'b1;
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_rel_nx   = 1'b0;
        end else if (r_state == S_MUL_WAIT) begin
            w_pc_we    = 1'b0;
            w_ifid_we  = 1'b0;
            w_idex_we  = 1'b0;
            w_exmem_fl = 1'b1;
            w_cnt_nx   = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                w_state_nx = S_IDLE;
                w_rel_nx   = 1'b1;
            end
        end else if (r_mul_rel) begin
            w_rel_nx = 1'b0;
        end else if (w_mul_hit) begin
            w_pc_we    = 1'b0;
            w_ifid_we  = 1'b0;
            w_idex_we  = 1'b0;
            w_exmem_fl = 1'b1;
            if (L_MUL_TWO) begin
                w_rel_nx = 1'b1;
            end else begin
                w_state_nx = S_MUL_WAIT;
                w_cnt_nx   = L_MUL_INIT;
            end
        end else if (w_load_use) begin
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_idex_fl = 1'b1;
        end

        if (!Reset_n) begin
            w_pc_we    = 1'b1;
            w_ifid_we  = 1'b1;
            w_idex_we  = 1'b1;
            w_ifid_fl  = 1'b0;
            w_idex_fl  = 1'b0;
            w_exmem_fl = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mul_rel   <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_mul_rel <= w_rel_nx;
            if (!w_pc_we && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign hz.PCWrite     = w_pc_we;
    assign hz.IFIDWrite   = w_ifid_we;
    assign hz.IDEXWrite   = w_idex_we;
    assign hz.IFIDFlush   = w_ifid_fl;
    assign hz.IDEXFlush   = w_idex_fl;
    assign hz.EXMEMFlush  = w_exmem_fl;
    assign hz.Busy        = (r_state == S_MUL_WAIT);
    assign hz.StallCycles = r_stall_cnt;
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline control block that reads the ID/EX pipeline register contents and drives the write-enable and flush controls of the IF/ID, ID/EX and EX/MEM registers and the PC. It handles three cases:
- a one-cycle load-use stall;
- a multi-cycle stall while a multiply occupies EX;
- a three-stage flush when a taken branch resolves in MEM.

It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MUL_LATENCY, 4: number of cycles a multiply occupies EX. Legal range 1..8; 1 disables multiply stalls.
- CNT_W, 3: width of the internal multiply countdown counter.

Ports:
- Clk  in  1  pipeline clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- IDEX_MemRead_In  in  1  MemRead bit currently held in ID/EX.
- IDEX_Rt_In  in  5  Instruction[20:16] currently held in ID/EX (load destination).
- IDEX_IsMul_In  in  1  ID/EX holds a multiply.
- IFID_Rs_In  in  5  Instruction[25:21] of the instruction in ID.
- IFID_Rt_In  in  5  Instruction[20:16] of the instruction in ID.
- IFID_UsesRt_In  in  1  the ID instruction reads rt as a source.
- BranchTaken_In  in  1  branch in MEM is taken (Branch & Zero from EX/MEM).
- PCWrite  out  1  PC load enable.
- IFIDWrite  out  1  IF/ID load enable.
- IFIDFlush  out  1  clear IF/ID to a NOP.
- IDEXWrite  out  1  ID/EX load enable.
- IDEXFlush  out  1  clear ID/EX control bits (bubble).
- EXMEMFlush  out  1  clear EX/MEM control bits (bubble).
- Busy  out  1  state is MUL_WAIT.
- StallCycles  out  16  count of cycles with PCWrite=0; saturates at 16'hFFFF.

## Operation
- Registered state: State (IDLE, MUL_WAIT), Cnt[CNT_W-1:0], MulRelease (1 bit), StallCycles.
- All control outputs are combinational from the state and the inputs.
- Default outputs: PCWrite=IFIDWrite=IDEXWrite=1, all Flush outputs=0.
- Priority 1, taken branch (BranchTaken_In=1, any state):
  - IFIDFlush=IDEXFlush=EXMEMFlush=1; all Write outputs=1.
  - Next state: State<=IDLE, Cnt<=0, MulRelease<=0.
  - A multiply in progress is aborted, because the multiply is younger than the branch.
- Priority 2, MUL_WAIT:
  - Outputs: PCWrite=IFIDWrite=IDEXWrite=0, EXMEMFlush=1.
  - Cnt decrements each cycle.
  - When Cnt==1: State<=IDLE and MulRelease<=1.
- Priority 3, multiply detect (IDLE, IDEX_IsMul_In=1, MulRelease=0, MUL_LATENCY>=2):
  - Outputs are the same as MUL_WAIT.
  - If MUL_LATENCY==2: stay in IDLE with MulRelease<=1.
  - Otherwise: State<=MUL_WAIT, Cnt<=MUL_LATENCY-2.
- Release cycle (IDLE, MulRelease=1): default outputs, so the multiply advances. MulRelease<=0.
- Priority 4, load-use (IDLE, IDEX_MemRead_In=1, IDEX_Rt_In!=0, and IDEX_Rt_In==IFID_Rs_In or (IFID_UsesRt_In and IDEX_Rt_In==IFID_Rt_In)):
  - Outputs: PCWrite=IFIDWrite=0, IDEXFlush=1, IDEXWrite=1.
  - No state change. The stall clears on its own the next cycle, when the bubble sits in ID/EX.
- A load whose destination is $0 never stalls.
- StallCycles increments on every edge where PCWrite=0 and stops at 16'hFFFF.

## Timing
- Reset (Reset_n low, asynchronous):
  - State=IDLE, Cnt=0, MulRelease=0, StallCycles=0.
  - While asserted, outputs are forced to PCWrite=IFIDWrite=IDEXWrite=1, all Flush=0, Busy=0.
- Reset in the middle of MUL_WAIT returns to IDLE immediately, with no release cycle.
- Load-use: exactly 1 stall cycle.
- Multiply: MUL_LATENCY-1 stall cycles. The multiply stays in ID/EX for MUL_LATENCY cycles and leaves on the release edge.
- Busy is high for MUL_LATENCY-2 cycles, covering the MUL_WAIT cycles only.
- Taken branch: the flush takes effect on the same edge; zero extra cycles.
- If BranchTaken_In and a load-use condition occur in the same cycle, the branch wins and no stall is issued.
- If a taken branch occurs during MUL_WAIT, the flush takes effect that edge and the next cycle is IDLE with default outputs.

## Test plan
- Load-use hazard:
  - Stimulus: IDEX_MemRead_In=1, IDEX_Rt_In=5'd8, IFID_Rs_In=5'd8 for 1 cycle.
  - Required: PCWrite=0, IFIDWrite=0, IDEXFlush=1 that cycle; default outputs next cycle; StallCycles=1.
- Load into $0:
  - Stimulus: IDEX_Rt_In=0 matching IFID_Rs_In=0, IDEX_MemRead_In=1.
  - Required: no stall; PCWrite=1.
- Rt-only match:
  - Stimulus: IDEX_Rt_In=9, IFID_Rt_In=9, IFID_Rs_In=3, first with IFID_UsesRt_In=0, then with IFID_UsesRt_In=1.
  - Required: no stall with 0; 1-cycle stall with 1.
- Multiply, MUL_LATENCY=4:
  - Stimulus: hold IDEX_IsMul_In=1 until the release cycle.
  - Required: 3 stall cycles with EXMEMFlush=1; Busy high for cycles 2-3 only; 4th cycle has IDEXWrite=1; StallCycles=3.
- Branch abort:
  - Stimulus: during MUL_WAIT, assert BranchTaken_In=1.
  - Required: all three Flush outputs=1 and PCWrite=1 that cycle; Busy=0 next cycle.
- Reset and saturation:
  - Stimulus: drop Reset_n in the middle of MUL_WAIT.
  - Required: immediate Busy=0 and StallCycles=0.
  - Stimulus: separately, 70000 consecutive load-use stalls.
  - Required: StallCycles holds at 16'hFFFF.
